// File: rtl/ascii_pkg.sv
// Shared definitions for the ASCII frame path: character constants, the
// frame FSM state type and the digit selection / leading-zero blanking helper.
package ascii_pkg;

  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_LF    = 8'h0A;
  localparam logic [7:0] CHAR_ZERO  = 8'h30;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIGIT = 2'd1,
    CR    = 2'd2,
    LF    = 2'd3
  } state_t;

  // Select byte idx of a packed word (idx 0 = thousands in [7:0]). With
  // lz_blank set, a byte at idx 0..2 becomes a space when it and every
  // earlier byte are '0'. The ones digit (idx 3) is never blanked.
  function automatic logic [7:0] digit_byte(input logic [31:0] word,
                                            input logic [1:0]  idx,
                                            input logic        lz_blank);
    logic [7:0] raw;
    logic       blank;
    logic       z0;
    logic       z1;
    logic       z2;
    z0    = (word[7:0]   == CHAR_ZERO);
    z1    = (word[15:8]  == CHAR_ZERO);
    z2    = (word[23:16] == CHAR_ZERO);
    raw   = 8'h00;
    blank = 1'b0;
    case (idx)
      2'd0: begin
        raw   = word[7:0];
        blank = z0;
      end
      2'd1: begin
        raw   = word[15:8];
        blank = z0 & z1;
      end
      2'd2: begin
        raw   = word[23:16];
        blank = z0 & z1 & z2;
      end
      2'd3: begin
        raw   = word[31:24];
        blank = 1'b0;
      end
      default: begin
        raw   = 8'h00;
        blank = 1'b0;
      end
    endcase
    if (lz_blank && blank) begin
      return CHAR_SPACE;
    end else begin
      return raw;
    end
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. The grant decision is combinational; the
// last-served register only moves when the caller strobes i_grant_en and a
// request is actually present. Last-served resets to 1 so requester 0 wins
// the first tie.
module rr_arbiter2 (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  input  logic       i_grant_en,
  output logic       o_grant_id,
  output logic       o_grant_valid
);

  logic r_last;
  logic w_grant_id;
  logic w_grant_valid;

  // Pick the winner: a sole requester wins, a tie goes to the one not served last.
  always_comb begin
    w_grant_id    = 1'b0;
    w_grant_valid = 1'b0;
    case (i_req)
      2'b01: begin
        w_grant_id    = 1'b0;
        w_grant_valid = 1'b1;
      end
      2'b10: begin
        w_grant_id    = 1'b1;
        w_grant_valid = 1'b1;
      end
      2'b11: begin
        w_grant_id    = ~r_last;
        w_grant_valid = 1'b1;
      end
      default: begin
        w_grant_id    = 1'b0;
        w_grant_valid = 1'b0;
      end
    endcase
  end

  // Remember who was served last, updated only on an accepted grant.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_last <= 1'b1;
    end else if (i_grant_en && w_grant_valid) begin
      r_last <= w_grant_id;
    end else begin
      r_last <= r_last;
    end
  end

  assign o_grant_id    = w_grant_id;
  assign o_grant_valid = w_grant_valid;

endmodule

// File: rtl/ascii_frame_arbiter.sv
// Shares one byte stream towards the UART TX between two ASCII-word
// requesters. A granted word is latched, then sent thousands digit first,
// with optional leading-zero blanking and an optional CR/LF trailer.
// All outputs are registered.
module ascii_frame_arbiter
  import ascii_pkg::*;
#(
  parameter bit EOL_EN   = 1'b1,
  parameter bit LZ_BLANK = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [1:0]  i_req,
  input  logic [31:0] i_word0,
  input  logic [31:0] i_word1,
  output logic [1:0]  o_ack,
  output logic        o_grant_id,
  output logic        o_busy,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready
);

  state_t      r_state;
  logic [1:0]  r_idx;
  logic [31:0] r_word;
  logic [7:0]  r_tx_data;
  logic        r_tx_valid;
  logic [1:0]  r_ack;
  logic        r_busy;
  logic        r_grant_id;

  state_t      w_state_nxt;
  logic [1:0]  w_idx_nxt;
  logic [31:0] w_word_nxt;
  logic [7:0]  w_tx_data_nxt;
  logic        w_tx_valid_nxt;
  logic [1:0]  w_ack_nxt;
  logic        w_busy_nxt;
  logic        w_grant_id_nxt;

  logic        w_arb_id;
  logic        w_arb_valid;
  logic        w_arb_en;
  logic        w_hs;
  logic [1:0]  w_idx_inc;
  logic [31:0] w_granted_word;

  // Requests are only considered while idle; anything else is ignored.
  assign w_arb_en  = (r_state == IDLE);
  assign w_hs      = r_tx_valid & i_tx_ready;
  assign w_idx_inc = r_idx + 2'd1;

  rr_arbiter2 u_arb (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_req         (i_req),
    .i_grant_en    (w_arb_en),
    .o_grant_id    (w_arb_id),
    .o_grant_valid (w_arb_valid)
  );

  // Next-state and next-output logic; every register holds unless a grant or handshake moves it.
  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_word_nxt     = r_word;
    w_tx_data_nxt  = r_tx_data;
    w_tx_valid_nxt = r_tx_valid;
    w_ack_nxt      = 2'b00;
    w_busy_nxt     = r_busy;
    w_grant_id_nxt = r_grant_id;
    w_granted_word = w_arb_id ? i_word1 : i_word0;

    case (r_state)
      IDLE: begin
        if (w_arb_valid) begin
          // Byte 0 comes from the word being latched, so the first byte is
          // presented in the same cycle as the ack pulse.
          w_state_nxt    = DIGIT;
          w_idx_nxt      = 2'd0;
          w_word_nxt     = w_granted_word;
          w_tx_data_nxt  = digit_byte(w_granted_word, 2'd0, LZ_BLANK);
          w_tx_valid_nxt = 1'b1;
          w_busy_nxt     = 1'b1;
          w_grant_id_nxt = w_arb_id;
          w_ack_nxt      = w_arb_id ? 2'b10 : 2'b01;
        end else begin
          w_tx_valid_nxt = 1'b0;
          w_busy_nxt     = 1'b0;
        end
      end

      DIGIT: begin
        if (w_hs) begin
          if (r_idx != 2'd3) begin
            w_idx_nxt     = w_idx_inc;
            w_tx_data_nxt = digit_byte(r_word, w_idx_inc, LZ_BLANK);
          end else if (EOL_EN) begin
            w_state_nxt   = CR;
            w_idx_nxt     = 2'd0;
            w_tx_data_nxt = CHAR_CR;
          end else begin
            w_state_nxt    = IDLE;
            w_idx_nxt      = 2'd0;
            w_tx_valid_nxt = 1'b0;
            w_busy_nxt     = 1'b0;
          end
        end else begin
          w_state_nxt = DIGIT;
        end
      end

      CR: begin
        if (w_hs) begin
          w_state_nxt   = LF;
          w_tx_data_nxt = CHAR_LF;
        end else begin
          w_state_nxt = CR;
        end
      end

      LF: begin
        if (w_hs) begin
          w_state_nxt    = IDLE;
          w_tx_valid_nxt = 1'b0;
          w_busy_nxt     = 1'b0;
        end else begin
          w_state_nxt = LF;
        end
      end

      default: begin
        w_state_nxt    = IDLE;
        w_idx_nxt      = 2'd0;
        w_tx_valid_nxt = 1'b0;
        w_busy_nxt     = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any frame in progress.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_idx      <= 2'd0;
      r_word     <= 32'h0000_0000;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_ack      <= 2'b00;
      r_busy     <= 1'b0;
      r_grant_id <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_word     <= w_word_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_tx_valid <= w_tx_valid_nxt;
      r_ack      <= w_ack_nxt;
      r_busy     <= w_busy_nxt;
      r_grant_id <= w_grant_id_nxt;
    end
  end

  assign o_ack      = r_ack;
  assign o_grant_id = r_grant_id;
  assign o_busy     = r_busy;
  assign o_tx_data  = r_tx_data;
  assign o_tx_valid = r_tx_valid;

endmodule

// File: tb/tb_ascii_frame_arbiter.sv
// Scoreboard bench for ascii_frame_arbiter. Two instances share the same
// stimulus: instance 0 uses the default configuration (CR/LF on, no
// blanking), instance 1 blanks leading zeros and has no CR/LF. A frame-level
// reference model pushes the expected byte list of each granted frame into a
// per-instance queue; a negedge monitor compares outputs against it.
`timescale 1ns/1ps
module tb_ascii_frame_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req;
  logic [31:0] word0;
  logic [31:0] word1;
  logic        tx_ready;

  logic [1:0]  ack      [2];
  logic        grant_id [2];
  logic        busy     [2];
  logic [7:0]  tx_data  [2];
  logic        tx_valid [2];

  always #5 clk = ~clk;

  ascii_frame_arbiter #(.EOL_EN(1'b1), .LZ_BLANK(1'b0)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_word0(word0), .i_word1(word1),
    .o_ack(ack[0]), .o_grant_id(grant_id[0]), .o_busy(busy[0]),
    .o_tx_data(tx_data[0]), .o_tx_valid(tx_valid[0]), .i_tx_ready(tx_ready)
  );

  ascii_frame_arbiter #(.EOL_EN(1'b0), .LZ_BLANK(1'b1)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_word0(word0), .i_word1(word1),
    .o_ack(ack[1]), .o_grant_id(grant_id[1]), .o_busy(busy[1]),
    .o_tx_data(tx_data[1]), .o_tx_valid(tx_valid[1]), .i_tx_ready(tx_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  // Expected {grant_id, byte} per instance.
  logic [8:0] exq0 [$];
  logic [8:0] exq1 [$];

  // Frame-level model state per instance.
  bit         m_busy [2];
  int         m_left [2];
  bit         m_last [2];
  logic [1:0] m_ack  [2];

  function automatic bit cfg_eol(input int d);
    return (d == 0);
  endfunction

  function automatic bit cfg_lz(input int d);
    return (d == 1);
  endfunction

  task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at %0t", name, d, act, exp, $time);
    end
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? exq0.size() : exq1.size();
  endfunction

  function automatic logic [8:0] qfront(input int d);
    return (d == 0) ? exq0[0] : exq1[0];
  endfunction

  task automatic qpush(input int d, input logic [8:0] v);
    if (d == 0) exq0.push_back(v);
    else        exq1.push_back(v);
  endtask

  task automatic qpop(input int d);
    if (d == 0) void'(exq0.pop_front());
    else        void'(exq1.pop_front());
  endtask

  task automatic qflush(input int d);
    if (d == 0) exq0.delete();
    else        exq1.delete();
  endtask

  // Expected byte sequence of one frame, from the formatting rules.
  task automatic push_frame(input int d, input bit id, input logic [31:0] w);
    logic [7:0] b;
    bit         lead;
    lead = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b    = w[8*i +: 8];
      lead = lead && (b == 8'h30);
      if (cfg_lz(d) && (i < 3) && lead) b = 8'h20;
      qpush(d, {id, b});
    end
    if (cfg_eol(d)) begin
      qpush(d, {id, 8'h0D});
      qpush(d, {id, 8'h0A});
    end
  endtask

  // Reference model: decides grants from the sampled requests and counts
  // accepted bytes until the frame is done.
  initial begin : model
    bit win;
    forever begin
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!rst_n) begin
          m_busy[d] = 1'b0;
          m_left[d] = 0;
          m_last[d] = 1'b1;
          m_ack[d]  = 2'b00;
          qflush(d);
        end else if (!m_busy[d]) begin
          m_ack[d] = 2'b00;
          if (req != 2'b00) begin
            if (req == 2'b01)      win = 1'b0;
            else if (req == 2'b10) win = 1'b1;
            else                   win = !m_last[d];
            m_last[d] = win;
            push_frame(d, win, win ? word1 : word0);
            m_left[d] = cfg_eol(d) ? 6 : 4;
            m_busy[d] = 1'b1;
            m_ack[d]  = win ? 2'b10 : 2'b01;
          end
        end else begin
          m_ack[d] = 2'b00;
          if (tx_ready) begin
            m_left[d]--;
            if (m_left[d] == 0) m_busy[d] = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: compares the presented outputs against the model on the falling edge.
  initial begin : monitor
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        for (int d = 0; d < 2; d++) begin
          check("tx_valid", d, {31'd0, tx_valid[d]}, {31'd0, m_busy[d]});
          check("busy", d, {31'd0, busy[d]}, {31'd0, m_busy[d]});
          check("ack", d, {30'd0, ack[d]}, {30'd0, m_ack[d]});
          if (m_busy[d]) begin
            if (qsize(d) == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL exp_queue dut%0d: byte presented with no expected byte at %0t", d, $time);
            end else begin
              e = qfront(d);
              check("tx_data", d, {24'd0, tx_data[d]}, {24'd0, e[7:0]});
              check("grant_id", d, {31'd0, grant_id[d]}, {31'd0, e[8]});
              if (tx_ready) qpop(d);
            end
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    int          r;
    w = 32'h0;
    for (int i = 0; i < 4; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4)      w[8*i +: 8] = 8'h30;
      else if (r < 9) w[8*i +: 8] = 8'h30 + 8'($urandom_range(0, 9));
      else            w[8*i +: 8] = 8'($urandom_range(0, 255));
    end
    return w;
  endfunction

  // Stimulus: directed scenarios, then randomized traffic, then drain.
  initial begin : stim
    rst_n    = 1'b0;
    req      = 2'b00;
    word0    = 32'h0;
    word1    = 32'h0;
    tx_ready = 1'b0;
    step(3);
    for (int d = 0; d < 2; d++) begin
      check("rst_tx_data", d, {24'd0, tx_data[d]}, 32'h0);
      check("rst_grant_id", d, {31'd0, grant_id[d]}, 32'h0);
    end
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Single frame at full rate.
    word0    = 32'h3935_3131;
    tx_ready = 1'b1;
    req      = 2'b01;
    step(2);
    req = 2'b00;
    step(8);

    // Same frame under backpressure 1,0,0,1,...
    req = 2'b01;
    for (int i = 0; i < 28; i++) begin
      tx_ready = ((i % 4) == 0) || ((i % 4) == 3);
      if (i == 2) req = 2'b00;
      step(1);
    end
    tx_ready = 1'b1;
    step(8);

    // Tie and fairness from a fresh last-served state.
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    word0 = 32'h3030_3031;
    word1 = 32'h3232_3232;
    req   = 2'b11;
    step(40);
    req = 2'b00;
    step(8);

    // Leading-zero words.
    word0 = 32'h3234_3030;
    word1 = 32'h3030_3030;
    req   = 2'b11;
    step(20);
    req = 2'b00;
    step(8);

    // Reset after the second byte of a frame, then requester 1 alone.
    word0 = 32'h3935_3131;
    word1 = 32'h3433_3231;
    req   = 2'b01;
    step(1);
    req = 2'b00;
    step(2);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    req   = 2'b10;
    step(1);
    req = 2'b00;
    step(10);

    // Randomized traffic with stalls, withdrawals, word changes and resets.
    for (int i = 0; i < 2000; i++) begin
      req = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) word0 = rand_word();
      if ($urandom_range(0, 7) == 0) word1 = rand_word();
      tx_ready = ($urandom_range(0, 3) != 0);
      rst_n    = ($urandom_range(0, 299) != 0);
      step(1);
    end

    // Drain and confirm every expected byte was delivered.
    rst_n    = 1'b1;
    req      = 2'b00;
    tx_ready = 1'b1;
    step(12);
    for (int d = 0; d < 2; d++) begin
      check("drain_queue_empty", d, qsize(d), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
